alu_cmd_queue: RTL and testbench

//  Upstream command stage for the byte ALU. Samples opcode/data pins on a strobe pin's rising edge.

---
 rtl/alu_pkg.sv | 9 +
 rtl/alu_cmd_queue_if.sv | 9 +
 rtl/strobe_sync_edge.sv | 22 ++
 rtl/alu_cmd_queue.sv | 63 ++++++
 tb/tb_alu_cmd_queue.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: command field widths and the packed command shared by the queue and the ALU
package alu_pkg;
  localparam int OPCODE_W = 4;
  localparam int DATA_W = 8;
  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [DATA_W-1:0] data;
  } alu_cmd_t;
endpackage

// File: rtl/alu_cmd_queue_if.sv
// alu_cmd_queue_if: valid/ready command channel from the queue to the ALU
interface alu_cmd_queue_if import alu_pkg::*; ();
  logic alu_valid;
  logic alu_ready;
  logic [OPCODE_W-1:0] alu_opcode;
  logic [DATA_W-1:0] alu_data;
  modport master (output alu_valid, alu_opcode, alu_data, input alu_ready);
  modport slave (input alu_valid, alu_opcode, alu_data, output alu_ready);
endinterface

// File: rtl/strobe_sync_edge.sv
// strobe_sync_edge: synchronizes an async strobe and emits a one-cycle pulse on its rising edge
module strobe_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);
  logic [STAGES-1:0] sync;
  logic hist;
  // reset high so a strobe already asserted out of reset is not taken as an edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= '1;
      hist <= 1'b1;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      hist <= sync[STAGES-1];
    end
  assign pulse = sync[STAGES-1] & ~hist;
endmodule

// File: rtl/alu_cmd_queue.sv
// alu_cmd_queue: queues strobed pin commands and hands them to the ALU over valid/ready
module alu_cmd_queue import alu_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_strobe,
  input  logic [OPCODE_W-1:0] pin_opcode,
  input  logic [DATA_W-1:0] pin_data,
  input  logic flush,
  alu_cmd_queue_if.master alu,
  output logic [$clog2(DEPTH):0] count,
  output logic full,
  output logic empty,
  output logic overflow
);
  localparam int AW = $clog2(DEPTH);
  typedef logic [AW-1:0] ptr_t;
  alu_cmd_t mem [DEPTH];
  alu_cmd_t head, cmd_in;
  ptr_t rd_ptr, wr_ptr;
  logic push, pop, wr_en, drop;
  strobe_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst_n(rst_n),
    .din(pin_strobe),
    .pulse(push)
  );
  assign cmd_in = '{opcode: pin_opcode, data: pin_data};
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign pop = alu.alu_valid & alu.alu_ready;
  assign wr_en = push & (~full | pop);
  assign drop = push & full & ~pop;
  assign alu.alu_valid = ~empty;
  assign alu.alu_opcode = head.opcode;
  assign alu.alu_data = head.data;
  always_ff @(posedge clk)
    if (wr_en && !flush) mem[wr_ptr] <= cmd_in;
  // head is a register: it loads the incoming command only when the queue is
  // otherwise empty after this cycle's pop, else the entry behind the popped one
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      head <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop) rd_ptr <= rd_ptr + ptr_t'(1);
      count <= count + (AW+1)'(wr_en) - (AW+1)'(pop);
      if (drop) overflow <= 1'b1;
      if (wr_en && count == (AW+1)'(pop)) head <= cmd_in;
      else if (pop) head <= mem[rd_ptr + ptr_t'(1)];
    end
endmodule

// File: tb/tb_alu_cmd_queue.sv
// tb_alu_cmd_queue: directed stimulus with a scoreboard checked by an independent output monitor
module tb_alu_cmd_queue;
  import alu_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pin_strobe = 1'b1;
  logic [3:0] pin_opcode = '0;
  logic [7:0] pin_data = '0;
  logic flush = 1'b0;
  logic [2:0] count;
  logic full, empty, overflow;
  int checks = 0;
  int errors = 0;
  logic [11:0] sb[$];
  alu_cmd_queue_if aif ();
  alu_cmd_queue #(.DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pin_strobe(pin_strobe),
    .pin_opcode(pin_opcode),
    .pin_data(pin_data),
    .flush(flush),
    .alu(aif.master),
    .count(count),
    .full(full),
    .empty(empty),
    .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic push_cmd(input logic [3:0] op, input logic [7:0] d, input bit accepted);
    pin_opcode = op;
    pin_data = d;
    if (accepted) sb.push_back({op, d});
    pin_strobe = 1'b1;
    repeat (3) tick();
    pin_strobe = 1'b0;
    repeat (3) tick();
  endtask
  task automatic drain(input string name);
    int n = 0;
    while (!empty && n < 40) begin
      tick();
      n++;
    end
    chk(name, {31'd0, empty}, 32'd1);
  endtask
  always @(negedge clk)
    if (rst_n && !flush && aif.alu_valid && aif.alu_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL alu_cmd: got unexpected %0h/%0h expected none", aif.alu_opcode, aif.alu_data);
      end else
        chk("alu_cmd", {20'd0, aif.alu_opcode, aif.alu_data}, {20'd0, sb.pop_front()});
    end
  initial begin
    aif.alu_ready = 1'b0;
    #1;
    chk("reset_count", 32'(count), 0);
    chk("reset_flags", {28'd0, aif.alu_valid, empty, full, overflow}, 32'b0100);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("strobe_high_no_push", {28'd0, count, aif.alu_valid}, 0);
    end
    tick();
    pin_strobe = 1'b0;
    repeat (3) tick();
    // single command latency
    aif.alu_ready = 1'b1;
    pin_opcode = 4'h3;
    pin_data = 8'h5A;
    sb.push_back({4'h3, 8'h5A});
    pin_strobe = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("latency_valid", {31'd0, aif.alu_valid}, {31'd0, i == 3});
    end
    chk("latency_count", 32'(count), 0);
    tick();
    pin_strobe = 1'b0;
    repeat (3) tick();
    // overfill with the ALU stalled
    aif.alu_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push_cmd(4'h1, 8'(i), i <= 4);
    chk("overfill_count", 32'(count), 4);
    chk("overfill_flags", {29'd0, full, overflow, empty}, 32'b110);
    aif.alu_ready = 1'b1;
    drain("overfill_drain");
    tick();
    chk("overflow_sticky", {31'd0, overflow}, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_clears_overflow", {31'd0, overflow}, 0);
    // push coinciding with a pop while full
    aif.alu_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push_cmd(4'h2, 8'hA0 + 8'(i), 1'b1);
    chk("full_before_pp", {31'd0, full}, 1);
    pin_opcode = 4'h5;
    pin_data = 8'hB5;
    sb.push_back({4'h5, 8'hB5});
    pin_strobe = 1'b1;
    tick();
    tick();
    aif.alu_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("pushpop_count", 32'(count), 4);
    chk("pushpop_overflow", {31'd0, overflow}, 0);
    tick();
    pin_strobe = 1'b0;
    drain("pushpop_drain");
    repeat (3) tick();
    // flush together with push pulse and pop
    aif.alu_ready = 1'b0;
    for (int i = 1; i <= 3; i++) push_cmd(4'h6, 8'hC0 + 8'(i), 1'b1);
    chk("pre_flush_count", 32'(count), 3);
    pin_opcode = 4'h7;
    pin_data = 8'hDD;
    pin_strobe = 1'b1;
    tick();
    tick();
    sb.delete();
    aif.alu_ready = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("flush_count", 32'(count), 0);
    chk("flush_flags", {29'd0, empty, aif.alu_valid, overflow}, 32'b100);
    tick();
    flush = 1'b0;
    pin_strobe = 1'b0;
    repeat (10) tick();
    chk("post_flush_count", 32'(count), 0);
    // async reset mid-stream
    aif.alu_ready = 1'b0;
    push_cmd(4'h8, 8'h11, 1'b1);
    push_cmd(4'h9, 8'h22, 1'b1);
    chk("pre_reset", {28'd0, count, aif.alu_valid}, {28'd0, 3'd2, 1'b1});
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset", {28'd0, count, aif.alu_valid}, 0);
    chk("async_reset_empty", {31'd0, empty}, 1);
    sb.delete();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    // pointer wrap over 3*DEPTH push/pop pairs
    aif.alu_ready = 1'b1;
    for (int i = 0; i < 12; i++) push_cmd(4'(i), 8'h10 + 8'(i), 1'b1);
    chk("wrap_count", 32'(count), 0);
    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
